// File: rtl/buffer_arb_pkg.sv
// Shared types and constants for the packet-buffer access arbiter.
package buffer_arb_pkg;

    localparam int unsigned BUFFER_DEPTH_DEF = 64;
    localparam int unsigned OCC_WIDTH_DEF    = 7;

    // Bit positions of each requester inside the request/winner vectors.
    localparam int unsigned REQ_AHB = 0;
    localparam int unsigned REQ_RX  = 1;
    localparam int unsigned REQ_TX  = 2;

    typedef enum logic [2:0] {
        IDLE,
        AHB_OWN,
        RX_OWN,
        TX_OWN,
        CLEAR
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_AHB = 2'd0,
        OWN_RX  = 2'd1,
        OWN_TX  = 2'd2
    } owner_t;

endpackage

// File: rtl/buffer_access_arbiter_rr_picker3.sv
// Three-way round-robin picker: the requester following the last owner
// in the ring AHB -> RX -> TX -> AHB gets first refusal. Purely combinational.
module rr_picker3
    import buffer_arb_pkg::*;
(
    input  logic [2:0] req,
    input  owner_t     last_owner,
    output logic [2:0] winner
);

    // Scan the ring starting just after the last owner.
    always_comb begin
        winner = 3'b000;
        case (last_owner)
            OWN_AHB: begin
                if (req[REQ_RX])       winner[REQ_RX]  = 1'b1;
                else if (req[REQ_TX])  winner[REQ_TX]  = 1'b1;
                else if (req[REQ_AHB]) winner[REQ_AHB] = 1'b1;
            end
            OWN_RX: begin
                if (req[REQ_TX])       winner[REQ_TX]  = 1'b1;
                else if (req[REQ_AHB]) winner[REQ_AHB] = 1'b1;
                else if (req[REQ_RX])  winner[REQ_RX]  = 1'b1;
            end
            default: begin
                if (req[REQ_AHB])      winner[REQ_AHB] = 1'b1;
                else if (req[REQ_RX])  winner[REQ_RX]  = 1'b1;
                else if (req[REQ_TX])  winner[REQ_TX]  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/buffer_access_arbiter.sv
// Packet-buffer access arbiter: grants the 64-byte buffer to one of AHB,
// USB RX or USB TX at a time, gates their strobes against ownership and
// occupancy, and services flush requests with top priority.
// Optional: define BUFFER_ARB_TIMEOUT_EN to revoke ownership from an owner
// that goes TIMEOUT_CYCLES cycles without a successful strobe.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; round-robin winner (if any) is granted next cycle
// AHB_OWN | AHB slave owns the buffer (buffer_reserved high)
// RX_OWN  | USB RX owns the buffer
// TX_OWN  | USB TX owns the buffer
// CLEAR   | one-cycle flush pulse, all grants low, then back to IDLE
module buffer_access_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int unsigned BUFFER_DEPTH   = BUFFER_DEPTH_DEF,
    parameter int unsigned OCC_WIDTH      = OCC_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req,
    input  logic                 ahb_req,
    input  logic                 ahb_release,
    input  logic                 ahb_strobe,
    input  logic                 ahb_write,
    input  logic [1:0]           ahb_size,
    input  logic                 rx_req,
    input  logic                 rx_release,
    input  logic                 rx_strobe,
    input  logic                 tx_req,
    input  logic                 tx_release,
    input  logic                 tx_strobe,
    input  logic [OCC_WIDTH-1:0] buffer_occupancy,
    output logic                 ahb_grant,
    output logic                 rx_grant,
    output logic                 tx_grant,
    output logic                 buffer_reserved,
    output logic                 store_tx_data,
    output logic                 get_rx_data,
    output logic                 store_rx_packet_data,
    output logic                 get_tx_packet_data,
    output logic                 clear,
    output logic                 overflow_err,
    output logic                 underflow_err,
    output logic                 timeout
);

    // One spare bit so occupancy + access size can never wrap.
    localparam int unsigned CW = OCC_WIDTH + 1;

    arb_state_t     state, state_nxt;
    owner_t         last_owner, last_owner_nxt;
    logic [2:0]     pick;
    logic           timeout_nxt;
    logic           to_expired;

    logic [CW-1:0]  occ_ext, ahb_n, depth_ext;
    logic           ahb_store_ok, ahb_fetch_ok, rx_store_ok, tx_fetch_ok;
    logic           owner_ok;
    logic           ovf_nxt, unf_nxt;

    assign occ_ext   = CW'(buffer_occupancy);
    assign ahb_n     = CW'(ahb_size) + CW'(1);
    assign depth_ext = CW'(BUFFER_DEPTH);

    // Capacity checks for each access type.
    assign ahb_store_ok = (occ_ext + ahb_n) <= depth_ext;
    assign ahb_fetch_ok = occ_ext >= ahb_n;
    assign rx_store_ok  = occ_ext < depth_ext;
    assign tx_fetch_ok  = occ_ext != '0;

    assign owner_ok = (state != CLEAR);

    // Same-cycle strobe gating: owner only, and only if capacity allows.
    assign store_tx_data        = ahb_grant & owner_ok & ahb_strobe &  ahb_write & ahb_store_ok;
    assign get_rx_data          = ahb_grant & owner_ok & ahb_strobe & ~ahb_write & ahb_fetch_ok;
    assign store_rx_packet_data = rx_grant  & owner_ok & rx_strobe  & rx_store_ok;
    assign get_tx_packet_data   = tx_grant  & owner_ok & tx_strobe  & tx_fetch_ok;

    // Owner strobes rejected on capacity; non-owner strobes are never errors.
    assign ovf_nxt = (ahb_grant & owner_ok & ahb_strobe &  ahb_write & ~ahb_store_ok)
                   | (rx_grant  & owner_ok & rx_strobe  & ~rx_store_ok);
    assign unf_nxt = (ahb_grant & owner_ok & ahb_strobe & ~ahb_write & ~ahb_fetch_ok)
                   | (tx_grant  & owner_ok & tx_strobe  & ~tx_fetch_ok);

    assign buffer_reserved = ahb_grant;

    rr_picker3 u_rr_picker3 (
        .req        ({tx_req, rx_req, ahb_req}),
        .last_owner (last_owner),
        .winner     (pick)
    );

`ifdef BUFFER_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;
    logic            strobe_passed;

    assign strobe_passed = store_tx_data | get_rx_data | store_rx_packet_data | get_tx_packet_data;
    assign to_expired    = (to_cnt == '0) && !strobe_passed;

    // Idle-owner down-counter, reloaded while unowned and on every passed strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        end else if (state == IDLE || state == CLEAR || strobe_passed) begin
            to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TO_W'(1);
        end
    end
`else
    assign to_expired = 1'b0;
`endif

    // Next-state: clear first, then release/req-drop, then idle-owner revoke.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        timeout_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                end else if (pick[REQ_AHB]) begin
                    state_nxt      = AHB_OWN;
                    last_owner_nxt = OWN_AHB;
                end else if (pick[REQ_RX]) begin
                    state_nxt      = RX_OWN;
                    last_owner_nxt = OWN_RX;
                end else if (pick[REQ_TX]) begin
                    state_nxt      = TX_OWN;
                    last_owner_nxt = OWN_TX;
                end
            end
            AHB_OWN: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                end else if (ahb_release || !ahb_req) begin
                    state_nxt = IDLE;
                end else if (to_expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            RX_OWN: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                end else if (rx_release || !rx_req) begin
                    state_nxt = IDLE;
                end else if (to_expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            TX_OWN: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                end else if (tx_release || !tx_req) begin
                    state_nxt = IDLE;
                end else if (to_expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            CLEAR: begin
                // Always drop back to IDLE so a held clear_req yields separate pulses.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs; pointer reset makes AHB win first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_owner    <= OWN_TX;
            ahb_grant     <= 1'b0;
            rx_grant      <= 1'b0;
            tx_grant      <= 1'b0;
            clear         <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_nxt;
            last_owner    <= last_owner_nxt;
            ahb_grant     <= (state_nxt == AHB_OWN);
            rx_grant      <= (state_nxt == RX_OWN);
            tx_grant      <= (state_nxt == TX_OWN);
            clear         <= (state_nxt == CLEAR);
            overflow_err  <= ovf_nxt;
            underflow_err <= unf_nxt;
            timeout       <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Directed bench for buffer_access_arbiter. Inputs change on the falling
// edge; each step queues the expected output vector for the current cycle
// and compares it 1 time unit later, well away from the rising edge.
module tb_buffer_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_req;
    logic       ahb_req, ahb_release, ahb_strobe, ahb_write;
    logic [1:0] ahb_size;
    logic       rx_req, rx_release, rx_strobe;
    logic       tx_req, tx_release, tx_strobe;
    logic [6:0] buffer_occupancy;
    logic       ahb_grant, rx_grant, tx_grant, buffer_reserved;
    logic       store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data;
    logic       clear, overflow_err, underflow_err, timeout;

    always #5 clk = ~clk;

    buffer_access_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .clear_req            (clear_req),
        .ahb_req              (ahb_req),
        .ahb_release          (ahb_release),
        .ahb_strobe           (ahb_strobe),
        .ahb_write            (ahb_write),
        .ahb_size             (ahb_size),
        .rx_req               (rx_req),
        .rx_release           (rx_release),
        .rx_strobe            (rx_strobe),
        .tx_req               (tx_req),
        .tx_release           (tx_release),
        .tx_strobe            (tx_strobe),
        .buffer_occupancy     (buffer_occupancy),
        .ahb_grant            (ahb_grant),
        .rx_grant             (rx_grant),
        .tx_grant             (tx_grant),
        .buffer_reserved      (buffer_reserved),
        .store_tx_data        (store_tx_data),
        .get_rx_data          (get_rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .clear                (clear),
        .overflow_err         (overflow_err),
        .underflow_err        (underflow_err),
        .timeout              (timeout)
    );

    // Output vector bit masks (ahb_grant and buffer_reserved always together).
    localparam logic [11:0] A   = 12'h900;
    localparam logic [11:0] R   = 12'h400;
    localparam logic [11:0] T   = 12'h200;
    localparam logic [11:0] STW = 12'h080;
    localparam logic [11:0] GRD = 12'h040;
    localparam logic [11:0] SRX = 12'h020;
    localparam logic [11:0] GTX = 12'h010;
    localparam logic [11:0] CLR = 12'h008;
    localparam logic [11:0] OVF = 12'h004;
    localparam logic [11:0] UNF = 12'h002;
    localparam logic [11:0] TO  = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    logic [11:0] obs;
    assign obs = {ahb_grant, rx_grant, tx_grant, buffer_reserved,
                  store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data,
                  clear, overflow_err, underflow_err, timeout};

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input string tag, input logic [11:0] exp);
        exp_t e;
        sb_q.push_back('{tag: tag, exp: exp});
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet_strobes();
        ahb_release = 1'b0; ahb_strobe = 1'b0;
        rx_release  = 1'b0; rx_strobe  = 1'b0;
        tx_release  = 1'b0; tx_strobe  = 1'b0;
        clear_req   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet_strobes();
        ahb_req = 1'b1; rx_req = 1'b1; tx_req = 1'b1;
        ahb_write = 1'b1; ahb_size = 2'd0;
        buffer_occupancy = 7'd10;

        repeat (2) @(negedge clk);
        step("reset_hold", NONE);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        step("rst_release_idle", NONE);

        // Round robin with all requests held, each owner releasing with one strobe.
        ahb_strobe = 1'b1; ahb_release = 1'b1;
        step("rr_ahb_release_strobe", A | STW);
        quiet_strobes();
        step("rr_gap1", NONE);
        rx_strobe = 1'b1; rx_release = 1'b1;
        step("rr_rx", R | SRX);
        quiet_strobes();
        step("rr_gap2", NONE);
        tx_strobe = 1'b1; tx_release = 1'b1;
        step("rr_tx", T | GTX);
        quiet_strobes();
        step("rr_gap3", NONE);

        // AHB store overflow at occupancy 62, then a fitting 2-byte store.
        rx_req = 1'b0; tx_req = 1'b0;
        buffer_occupancy = 7'd62;
        ahb_strobe = 1'b1; ahb_write = 1'b1; ahb_size = 2'd3;
        step("ovf_block", A);
        ahb_size = 2'd1;
        step("ovf_pulse_store_pass", A | STW | OVF);

        // AHB fetch underflow, then a fetch that exactly drains; RX strobes as non-owner.
        buffer_occupancy = 7'd2;
        ahb_write = 1'b0; ahb_size = 2'd3;
        step("ahb_fetch_block", A);
        ahb_size = 2'd1;
        rx_strobe = 1'b1;
        step("ahb_fetch_pass", A | GRD | UNF);
        quiet_strobes();
        ahb_req = 1'b0; tx_req = 1'b1;
        step("nonowner_no_err", A);
        step("gap_to_tx", NONE);

        // TX fetch underflow at empty buffer, then passes with one byte.
        buffer_occupancy = 7'd0;
        tx_strobe = 1'b1;
        step("udf_block", T);
        buffer_occupancy = 7'd1;
        step("udf_pulse_fetch_pass", T | GTX | UNF);
        tx_strobe = 1'b0; tx_req = 1'b0; rx_req = 1'b1;
        step("tx_drop_req", T);
        step("gap_to_rx", NONE);

        // Clear while RX streams: strobe of that cycle is honoured, then the flush.
        buffer_occupancy = 7'd20;
        rx_strobe = 1'b1; clear_req = 1'b1;
        step("clr_same_cycle_strobe", R | SRX);
        clear_req = 1'b0;
        step("clr_pulse", CLR);
        step("clr_idle", NONE);
        step("rx_regain", R | SRX);
        buffer_occupancy = 7'd64;
        step("rx_full_block", R);
        rx_strobe = 1'b0;
        step("rx_ovf_pulse", R | OVF);

        // Held clear_req: separate pulses with IDLE between, beating a pending req.
        clear_req = 1'b1;
        step("clr_held_req", R);
        step("clr_held_pulse1", CLR);
        step("clr_held_idle", NONE);
        clear_req = 1'b0;
        step("clr_held_pulse2", CLR);
        step("clr_held_idle2", NONE);
        step("rx_after_clears", R);

        // Asynchronous reset mid-ownership, then pointer favours AHB again.
        rst = 1'b1; ahb_req = 1'b1;
        step("rst_async_drop", NONE);
        rst = 1'b0;
        step("rst_idle_again", NONE);
        step("rr_reset_ahb_first", A);

`ifdef BUFFER_ARB_TIMEOUT_EN
        step("to_wait1", A);
        step("to_wait2", A);
        step("to_wait3", A);
        step("to_pulse", TO);
        step("to_rx_wins", R);
`else
        step("no_revoke1", A);
        step("no_revoke2", A);
        step("no_revoke3", A);
        step("no_revoke4", A);
        step("no_revoke5", A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buffer_access_arbiter.md
Name: buffer_access_arbiter

Overview:
- Sequences and shares the 64-byte packet data buffer between three requesters: AHB-Lite slave (word store/fetch), USB RX (byte store) and USB TX (byte fetch).
- Grants exclusive ownership to one requester at a time and drives buffer_reserved.
- Gates every buffer strobe against ownership and occupancy, so the buffer never sees overflow, underflow or conflicting accesses.
- Services protocol-controller clear requests with top priority.

Parameters:
BUFFER_DEPTH, 64, buffer capacity in bytes
OCC_WIDTH, 7, width of buffer_occupancy (holds 0..BUFFER_DEPTH)
TIMEOUT_CYCLES, 255, idle-owner cycles before forced revoke (ARB_TIMEOUT_EN only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
clear_req  in  1  protocol controller requests buffer flush
ahb_req  in  1  AHB requests ownership (level)
ahb_release  in  1  AHB drops ownership (pulse)
ahb_strobe  in  1  AHB access this cycle
ahb_write  in  1  1 = store to buffer, 0 = fetch from buffer
ahb_size  in  2  bytes-1 of AHB access
rx_req / rx_release / rx_strobe  in  1 each  USB RX ownership and byte-store strobe
tx_req / tx_release / tx_strobe  in  1 each  USB TX ownership and byte-fetch strobe
buffer_occupancy  in  OCC_WIDTH  current buffer fill, from buffer
ahb_grant / rx_grant / tx_grant  out  1 each  registered ownership grants, one-hot or all zero
buffer_reserved  out  1  equals ahb_grant
store_tx_data / get_rx_data  out  1 each  gated AHB strobes to buffer
store_rx_packet_data / get_tx_packet_data  out  1 each  gated USB strobes to buffer
clear  out  1  buffer clear pulse
overflow_err / underflow_err  out  1 each  registered 1-cycle pulse on a rejected strobe
timeout  out  1  1-cycle pulse on forced revoke

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Round-robin pointer set so AHB wins the first contention.
  - rst asserted mid-operation drops all grants immediately.
- States: IDLE, AHB_OWN, RX_OWN, TX_OWN, CLEAR.
- IDLE: on any req, the round-robin winner is chosen. Order after last owner X is the next in AHB -> RX -> TX -> AHB. Its grant registers the next cycle (1-cycle req->grant latency).
- *_OWN:
  - Grant is held while req stays high.
  - A release pulse, or req deasserting, moves the state to IDLE. Grant drops on the next edge.
  - At least one IDLE cycle always separates two owners; no same-cycle handover.
- CLEAR:
  - clear_req in any state enters CLEAR next cycle: clear=1 for exactly one cycle, all grants 0.
  - Then IDLE. The round-robin pointer is unchanged.
  - clear_req held high produces repeated one-cycle clear pulses, each separated by IDLE.
- Strobe gating is combinational, same cycle. A strobe passes only when its grant is 1 and state is not CLEAR.
  - AHB store: n = ahb_size+1; passes if occupancy + n <= BUFFER_DEPTH. Compare at OCC_WIDTH+1 bits, no wrap.
  - AHB fetch: passes if occupancy >= n.
  - RX store: passes if occupancy < BUFFER_DEPTH.
  - TX fetch: passes if occupancy > 0.
  - A failed capacity check blocks the strobe and pulses overflow_err (store) or underflow_err (fetch) on the next cycle.
  - A strobe from a non-owner is silently ignored, with no error pulse.
- Simultaneous events:
  - clear_req beats everything.
  - A release and a strobe in the same cycle: the strobe is honoured, then release.
  - Multiple reqs in IDLE are resolved by round-robin only.

Optional Feature:
- Macro: BUFFER_ARB_TIMEOUT_EN.
- Defined:
  - A per-owner counter resets on grant and on every passed strobe, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, the grant is revoked: state goes to IDLE, timeout pulses 1 cycle, and the owner is treated as last-served.
- Undefined: no counter; timeout is tied 0; ownership is never revoked by the arbiter.

Decomposition:
- Package buffer_arb_pkg holds:
  - the state enum arb_state_t;
  - the owner enum owner_t {OWN_AHB, OWN_RX, OWN_TX};
  - constants BUFFER_DEPTH_DEF = 64 and OCC_WIDTH_DEF = 7.
- Sub-module rr_picker3: a 3-requester round-robin picker. Inputs are the req vector and last owner; output is the one-hot winner. It is purely combinational.

Test Plan:
1. Reset: rst pulse with all reqs high -> grants 0; after release of rst, ahb_grant=1 on the second edge.
2. Round-robin: ahb_req, rx_req, tx_req held high, each owner releases after 1 strobe -> grant order AHB, RX, TX, AHB, each separated by 1 IDLE cycle.
3. Overflow: AHB owner, occupancy=62, ahb_write=1, ahb_size=3, strobe -> store_tx_data=0 and overflow_err=1 next cycle; with ahb_size=1 -> store_tx_data=1.
4. Underflow: TX owner, occupancy=0, tx_strobe -> get_tx_packet_data=0, underflow_err=1; occupancy=1 -> passes.
5. Clear mid-ownership: RX owner streaming, clear_req for 1 cycle -> rx_grant=0 and clear=1 next cycle, then IDLE; RX regains grant 1 cycle later.
6. Timeout (BUFFER_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): AHB granted, no strobes -> timeout pulse and ahb_grant=0 after 4 cycles; a pending rx_req wins next.
